// File: rtl/cfg_context_seq.sv
// Per-PE configuration context store and sequencer.
// Loads a program of context words over a valid/ready port, then replays
// it one word per cycle on data_out for a programmed number of passes.
// Outside execution the all-zero NOP context is driven.
module cfg_context_seq #(
   parameter int unsigned WIDTH = 120,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned CW    = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH:0]   cfg_data,
   input  logic             cfg_last,
   input  logic             start,
   input  logic [CW-1:0]    iter_cnt,
   input  logic             stall,
   input  logic             abort,
   output logic [WIDTH:0]   data_out,
   output logic [AW-1:0]    ctx_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      LOADED = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH:0]   mem [DEPTH];
   logic [AW-1:0]    wr_ptr, wr_ptr_n;
   logic [AW:0]      num_ctx, num_ctx_n;
   logic [CW-1:0]    pass_cnt, pass_cnt_n;
   logic [WIDTH:0]   data_n;
   logic [AW-1:0]    idx_n;
   logic             done_n;
   logic             accept;
   logic             last_slot;
   logic [AW-1:0]    idx_inc;

   assign cfg_ready = (state == EMPTY);
   assign busy      = (state == RUN);
   // abort in EMPTY wins over a word offered in the same cycle
   assign accept    = cfg_valid && cfg_ready && !abort;
   assign last_slot = ({1'b0, ctx_idx} == (num_ctx - (AW+1)'(1)));
   assign idx_inc   = ctx_idx + AW'(1);

   // Context storage; deliberately not cleared by reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         mem[wr_ptr] <= cfg_data;
      end
   end

   // State, pointers, pass counter and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= EMPTY;
         wr_ptr   <= '0;
         num_ctx  <= '0;
         pass_cnt <= '0;
         data_out <= '0;
         ctx_idx  <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         wr_ptr   <= wr_ptr_n;
         num_ctx  <= num_ctx_n;
         pass_cnt <= pass_cnt_n;
         data_out <= data_n;
         ctx_idx  <= idx_n;
         done     <= done_n;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n    = state;
      wr_ptr_n   = wr_ptr;
      num_ctx_n  = num_ctx;
      pass_cnt_n = pass_cnt;
      data_n     = data_out;
      idx_n      = ctx_idx;
      done_n     = 1'b0;

      unique case (state)
         EMPTY: begin
            if (abort) begin
               wr_ptr_n = '0;
            end else if (accept) begin
               if (cfg_last || (wr_ptr == AW'(DEPTH - 1))) begin
                  num_ctx_n = {1'b0, wr_ptr} + (AW+1)'(1);
                  wr_ptr_n  = '0;
                  state_n   = LOADED;
               end else begin
                  wr_ptr_n = wr_ptr + AW'(1);
               end
            end
         end

         LOADED: begin
            if (abort) begin
               num_ctx_n = '0;
               wr_ptr_n  = '0;
               state_n   = EMPTY;
            end else if (start) begin
               pass_cnt_n = iter_cnt;
               data_n     = mem[0];
               idx_n      = '0;
               state_n    = RUN;
            end
         end

         RUN: begin
            if (abort) begin
               data_n  = '0;
               idx_n   = '0;
               state_n = LOADED;
            end else if (stall) begin
               // hold context, index and pass counter
            end else if (last_slot) begin
               if (pass_cnt == CW'(1)) begin
                  data_n  = '0;
                  idx_n   = '0;
                  done_n  = 1'b1;
                  state_n = LOADED;
               end else begin
                  // pass count 0 means run until abort
                  data_n = mem[0];
                  idx_n  = '0;
                  if (pass_cnt != '0) begin
                     pass_cnt_n = pass_cnt - CW'(1);
                  end
               end
            end else begin
               data_n = mem[idx_inc];
               idx_n  = idx_inc;
            end
         end

         default: begin
            state_n = EMPTY;
         end
      endcase
   end

endmodule

// File: tb/tb_cfg_context_seq.sv
// Directed testbench for cfg_context_seq with hand-computed expectations.
module tb_cfg_context_seq;

   localparam int unsigned WIDTH = 120;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned CW    = 16;

   logic             CLK;
   logic             RST_N;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH:0]   cfg_data;
   logic             cfg_last;
   logic             start;
   logic [CW-1:0]    iter_cnt;
   logic             stall;
   logic             abort;
   logic [WIDTH:0]   data_out;
   logic [AW-1:0]    ctx_idx;
   logic             busy;
   logic             done;

   int vectors;
   int miscompares;

   localparam logic [WIDTH:0] WA = {1'b1, 56'hA0A0_0000_0000_0A, 64'h1111_2222_3333_000A};
   localparam logic [WIDTH:0] WB = {1'b0, 56'hB0B0_0000_0000_0B, 64'h4444_5555_6666_000B};
   localparam logic [WIDTH:0] WC = {1'b1, 56'hC0C0_0000_0000_0C, 64'h7777_8888_9999_000C};

   logic [WIDTH:0] seq [3];

   cfg_context_seq #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .start     (start),
      .iter_cnt  (iter_cnt),
      .stall     (stall),
      .abort     (abort),
      .data_out  (data_out),
      .ctx_idx   (ctx_idx),
      .busy      (busy),
      .done      (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle just after it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_word(input logic [WIDTH:0] w, input logic last);
      cfg_valid = 1'b1;
      cfg_data  = w;
      cfg_last  = last;
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic do_start(input logic [CW-1:0] n);
      start    = 1'b1;
      iter_cnt = n;
      tick();
      start    = 1'b0;
   endtask

   function automatic logic [WIDTH:0] word_of(input int i);
      return {1'b1, 56'(i * 37 + 5), 64'hDEAD_BEEF_0000_0000 | 64'(i)};
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      seq[0] = WA;
      seq[1] = WB;
      seq[2] = WC;
      RST_N = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      cfg_last  = 1'b0;
      start     = 1'b0;
      iter_cnt  = '0;
      stall     = 1'b0;
      abort     = 1'b0;
      tick();
      tick();
      check_val("rst_data", 128'(data_out), 128'(0));
      check_val("rst_idx", 128'(ctx_idx), 128'(0));
      check_val("rst_busy", 128'(busy), 128'(0));
      check_val("rst_done", 128'(done), 128'(0));
      check_val("rst_ready", 128'(cfg_ready), 128'(1));
      RST_N = 1'b1;
      tick();

      // program A,B,C; two passes
      load_word(WA, 1'b0);
      load_word(WB, 1'b0);
      check_val("ld_ready_mid", 128'(cfg_ready), 128'(1));
      load_word(WC, 1'b1);
      check_val("ld_ready_end", 128'(cfg_ready), 128'(0));
      check_val("ld_nop", 128'(data_out), 128'(0));
      do_start(16'd2);
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("p2_data%0d", i), 128'(data_out), 128'(seq[i % 3]));
         check_val($sformatf("p2_idx%0d", i), 128'(ctx_idx), 128'(i % 3));
         check_val($sformatf("p2_busy%0d", i), 128'(busy), 128'(1));
         check_val($sformatf("p2_done%0d", i), 128'(done), 128'(0));
         tick();
      end
      check_val("p2_end_data", 128'(data_out), 128'(0));
      check_val("p2_end_done", 128'(done), 128'(1));
      check_val("p2_end_busy", 128'(busy), 128'(0));
      tick();
      check_val("p2_done_clr", 128'(done), 128'(0));

      // one pass with a 3-cycle stall on B
      do_start(16'd1);
      check_val("st_a", 128'(data_out), 128'(WA));
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("st_b%0d", i), 128'(data_out), 128'(WB));
         check_val($sformatf("st_idx%0d", i), 128'(ctx_idx), 128'(1));
         tick();
      end
      stall = 1'b0;
      check_val("st_b3", 128'(data_out), 128'(WB));
      check_val("st_idx3", 128'(ctx_idx), 128'(1));
      tick();
      check_val("st_c", 128'(data_out), 128'(WC));
      check_val("st_c_done", 128'(done), 128'(0));
      tick();
      check_val("st_end_data", 128'(data_out), 128'(0));
      check_val("st_end_done", 128'(done), 128'(1));

      // infinite mode, then abort
      tick();
      do_start(16'd0);
      for (int i = 0; i < 20; i++) begin
         check_val($sformatf("inf_data%0d", i), 128'(data_out), 128'(seq[i % 3]));
         tick();
      end
      check_val("inf_busy", 128'(busy), 128'(1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("ab_data", 128'(data_out), 128'(0));
      check_val("ab_busy", 128'(busy), 128'(0));
      check_val("ab_done", 128'(done), 128'(0));
      check_val("ab_ready", 128'(cfg_ready), 128'(0));
      tick();
      check_val("ab_done2", 128'(done), 128'(0));
      do_start(16'd1);
      check_val("rs_a", 128'(data_out), 128'(WA));
      tick();
      tick();
      check_val("rs_c", 128'(data_out), 128'(WC));
      tick();
      check_val("rs_done", 128'(done), 128'(1));

      // start and abort together in LOADED
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_val("sa_ready", 128'(cfg_ready), 128'(1));
      check_val("sa_data", 128'(data_out), 128'(0));
      check_val("sa_busy", 128'(busy), 128'(0));

      // full 16-word program without cfg_last
      for (int i = 0; i < 16; i++) begin
         check_val($sformatf("f_ready%0d", i), 128'(cfg_ready), 128'(1));
         load_word(word_of(i), 1'b0);
      end
      check_val("f_ready_end", 128'(cfg_ready), 128'(0));
      load_word('1, 1'b1);
      check_val("f_17th", 128'(cfg_ready), 128'(0));
      do_start(16'd1);
      for (int i = 0; i < 16; i++) begin
         check_val($sformatf("f_data%0d", i), 128'(data_out), 128'(word_of(i)));
         check_val($sformatf("f_idx%0d", i), 128'(ctx_idx), 128'(i));
         tick();
      end
      check_val("f_end_data", 128'(data_out), 128'(0));
      check_val("f_end_done", 128'(done), 128'(1));

      // reset in the middle of a run
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("re_empty", 128'(cfg_ready), 128'(1));
      load_word(WA, 1'b0);
      load_word(WB, 1'b0);
      load_word(WC, 1'b1);
      do_start(16'd0);
      tick();
      check_val("re_b", 128'(data_out), 128'(WB));
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check_val("re_data", 128'(data_out), 128'(0));
      check_val("re_busy", 128'(busy), 128'(0));
      check_val("re_ready", 128'(cfg_ready), 128'(1));
      check_val("re_idx", 128'(ctx_idx), 128'(0));
      do_start(16'd1);
      check_val("re_st_busy", 128'(busy), 128'(0));
      check_val("re_st_data", 128'(data_out), 128'(0));
      check_val("re_st_ready", 128'(cfg_ready), 128'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cfg_context_seq.md
Name: cfg_context_seq

Overview:
- Per-PE configuration context store and sequencer. It sits directly upstream of the PE field decoder.
- Accepts a program of WIDTH+1-bit context words over a valid/ready load port and holds them in local storage.
- On start, it replays the words one per cycle on data_out, which feeds the decoder's data_in bus, for a programmed number of passes.
- Outside execution it drives the all-zero NOP context.

Parameters:
WIDTH, 120, MSB index of the context word; the word is WIDTH+1 bits.
DEPTH, 16, number of context slots.
AW, 4, slot index width; DEPTH = 2**AW.
CW, 16, pass-counter width.

Ports:
CLK  input  1  clock; all logic on the rising edge.
RST_N  input  1  synchronous active-low reset.
cfg_valid  input  1  load word present.
cfg_ready  output  1  block accepts a load word; high only in EMPTY.
cfg_data  input  WIDTH+1  context word to store.
cfg_last  input  1  marks the final word of the program.
start  input  1  begin execution; honoured only in LOADED.
iter_cnt  input  CW  number of passes, sampled with start; 0 means run until abort.
stall  input  1  hold the current context.
abort  input  1  stop execution or discard the program.
data_out  output  WIDTH+1  context word to the decoder; registered.
ctx_idx  output  AW  slot index currently on data_out; registered.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse on normal completion.

Behaviour:
- States: EMPTY (loading), LOADED (program held, idle), RUN.
- Reset (RST_N=0 at an edge), regardless of current state:
  - state=EMPTY, data_out=0, ctx_idx=0, busy=0, done=0.
  - wr_ptr=0, num_ctx=0, pass counter=0.
  - cfg_ready=1 after reset. Storage contents are not cleared.
- EMPTY:
  - A word is accepted when cfg_valid & cfg_ready; it is written to mem[wr_ptr] and wr_ptr increments.
  - Program end: if the accepted word has cfg_last=1, or wr_ptr==DEPTH-1 (overflow guard), then num_ctx=wr_ptr+1, wr_ptr=0, and the next state is LOADED.
  - start is ignored. abort resets wr_ptr to 0 and stays in EMPTY.
- LOADED:
  - cfg_ready=0; cfg_valid is ignored.
  - abort: clear num_ctx and wr_ptr, go to EMPTY. abort has priority over start in the same cycle.
  - start at edge t: latch the pass counter from iter_cnt and enter RUN. At t+1, data_out=mem[0], ctx_idx=0, busy=1. Start-to-first-context latency is 1 cycle.
- RUN:
  - Priority at each edge: abort > stall > advance.
  - abort: at the next edge data_out=0, ctx_idx=0, busy=0, state=LOADED. No done pulse.
  - stall=1: data_out, ctx_idx and the pass counter all hold.
  - Advance with ctx_idx<num_ctx-1: ctx_idx increments and data_out=mem[ctx_idx+1].
  - Advance with ctx_idx==num_ctx-1 (wrap):
    - If the pass counter is 1: data_out=0, ctx_idx=0, busy=0, done=1 for exactly one cycle, state=LOADED.
    - Otherwise: ctx_idx=0 and data_out=mem[0]. The pass counter decrements if nonzero; it stays 0 in infinite mode.
  - num_ctx==1: the same word is emitted once per pass, back to back.
  - Each context appears on data_out for exactly (1 + stalled cycles) cycles. There are no bubbles between passes.
  - start and cfg_valid are ignored in RUN.
- A program stays resident across runs. start from LOADED replays it without reloading.
- Reset mid-load or mid-run aborts immediately, and a full reload is required afterwards.

Test Plan:
- Load A,B,C (cfg_last on C), then start with iter_cnt=2 → data_out sequence A,B,C,A,B,C,0. done=1 in the cycle data_out returns to 0. busy high for 6 cycles. cfg_ready=0 after C is accepted.
- Same program, iter_cnt=1, stall high for 3 cycles while B is shown → B held for 4 cycles, ctx_idx=1 throughout, then C, then 0 with a done pulse.
- iter_cnt=0 → A,B,C repeating for 20 cycles; abort → data_out=0 on the next edge, no done pulse, state=LOADED. A second start replays from A.
- Load 16 words with cfg_last=0 → cfg_ready drops after the 16th word and num_ctx=16. The 17th cfg_valid is not accepted. A run emits slots 0..15.
- In LOADED, assert start and abort in the same cycle → state=EMPTY, cfg_ready=1, data_out remains 0.
- RST_N=0 for one cycle mid-RUN while showing B → next edge: data_out=0, busy=0, cfg_ready=1. A start before reload is ignored.
